// File: rtl/sfifo_wr_arb_if.sv
// -----------------------------------------------------------------------------
// sfifo_wr_arb_if
// Bundles the producer handshake and the FIFO write-side signals of the
// round-robin write arbiter.
//   req_valid     per-producer beat valid
//   req_data      producer i occupies bits [i*DATA_W +: DATA_W]
//   req_ready     per-producer accept (at most one bit high)
//   fifo_full     FIFO full flag
//   fifo_overflow FIFO overflow flag
//   fifo_w_en     FIFO write enable (registered)
//   fifo_din      FIFO write data (registered)
// Modports:
//   master - producers plus FIFO (the environment around the arbiter)
//   slave  - the arbiter itself
// -----------------------------------------------------------------------------
interface sfifo_wr_arb_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      fifo_full;
   logic                      fifo_overflow;
   logic                      fifo_w_en;
   logic [DATA_W-1:0]         fifo_din;

   modport master (
      output req_valid, req_data, fifo_full, fifo_overflow,
      input  req_ready, fifo_w_en, fifo_din
   );

   modport slave (
      input  req_valid, req_data, fifo_full, fifo_overflow,
      output req_ready, fifo_w_en, fifo_din
   );
endinterface

// File: rtl/sfifo_wr_arb.sv
// -----------------------------------------------------------------------------
// sfifo_wr_arb
// Round-robin arbiter sharing the single write port of a byte FIFO among
// NUM_REQ valid/ready producers. A grant lasts up to BURST_MAX beats or until
// the producer drops valid; accepted beats reach the FIFO through one register
// stage. FIFO full stalls the burst, FIFO overflow is latched in ovf_err.
// Ports:
//   clk      sole clock, rising edge
//   rst      asynchronous reset, active-high
//   arb_en   enables new grants (a running grant always completes)
//   bus      producer handshake + FIFO write side (slave modport)
//   grant_id index of the current or last granted producer (registered)
//   busy     high while a grant is active (GRANT or STALL)
//   ovf_err  sticky FIFO overflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module sfifo_wr_arb #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int BURST_MAX = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arb_en,
   sfifo_wr_arb_if.slave              bus,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       ovf_err
);
   localparam int ID_W = $clog2(NUM_REQ);
   localparam logic [4:0] BURST_LIM = 5'(BURST_MAX);

   typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [3:0]        beat_cnt_q, beat_cnt_d;
   logic              w_en_q;
   logic [DATA_W-1:0] din_q;
   logic              ovf_q;

   logic [NUM_REQ-1:0] ready;
   logic               transfer;
   logic               rr_hit;
   logic [ID_W-1:0]    rr_idx;
   logic [4:0]         beat_inc;

   // Round-robin pick: first valid producer scanning upward from the one
   // after last_grant, wrapping around.
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!rr_hit && bus.req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
            rr_hit = 1'b1;
            rr_idx = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path
   //       leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      ready        = '0;
      transfer     = 1'b0;
      beat_inc     = {1'b0, beat_cnt_q} + 5'd1;

      unique case (state_q)
         IDLE: begin
            if (arb_en && rr_hit) begin
               grant_id_d = rr_idx;
               beat_cnt_d = '0;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            // Full gates ready in the same cycle so no beat is accepted
            // once the FIFO reports full.
            ready[grant_id_q] = !bus.fifo_full;
            transfer = bus.req_valid[grant_id_q] && !bus.fifo_full;
            if (transfer) beat_cnt_d = beat_inc[3:0];
            if (bus.fifo_full) begin
               state_d = STALL;
            end else if (transfer && beat_inc == BURST_LIM) begin
               last_grant_d = grant_id_q;
               state_d      = IDLE;
            end else if (!bus.req_valid[grant_id_q]) begin
               // Early release: a producer that drops valid loses its grant.
               last_grant_d = grant_id_q;
               state_d      = IDLE;
            end
         end
         STALL: begin
            if (!bus.fifo_full) state_d = GRANT;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   //       samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the output register is reset too, so a beat captured just
         //       before reset never reaches the FIFO as a spurious write.
         state_q      <= IDLE;
         grant_id_q   <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         beat_cnt_q   <= '0;
         w_en_q       <= 1'b0;
         din_q        <= '0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         w_en_q       <= transfer;
         if (transfer) din_q <= bus.req_data[int'(grant_id_q)*DATA_W +: DATA_W];
         ovf_q        <= ovf_q | bus.fifo_overflow;
      end
   end

   assign bus.req_ready = ready;
   assign bus.fifo_w_en = w_en_q;
   assign bus.fifo_din  = din_q;
   assign grant_id      = grant_id_q;
   assign busy          = (state_q != IDLE);
   assign ovf_err       = ovf_q;

endmodule

// File: doc/sfifo_wr_arb.md
# sfifo_wr_arb

Round-robin write arbiter that shares the single write port of the 64-entry byte FIFO among `NUM_REQ` producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for bursts of up to `BURST_MAX` beats and forwards accepted bytes to the FIFO's `w_en`/`din` through one register stage. It honours the FIFO `full` flag and records any FIFO overflow in a sticky error flag.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of producers, 2..8.
- `DATA_W`, default 8: beat width; must match the FIFO `din` width.
- `BURST_MAX`, default 4: maximum beats per grant before rotating, 1..15.

Ports (single clock `clk`; reset is asynchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `arb_en`  in  1  when low, no new grant is issued; a grant already in progress runs to its normal release.
- `req_valid`  in  NUM_REQ  per-producer beat-valid.
- `req_data`  in  NUM_REQ*DATA_W  producer i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  per-producer accept; at most one bit is high.
- `fifo_full`  in  1  FIFO `full` flag.
- `fifo_overflow`  in  1  FIFO `overflow` flag.
- `fifo_w_en`  out  1  drives FIFO `w_en`; registered.
- `fifo_din`  out  DATA_W  drives FIFO `din`; registered.
- `grant_id`  out  clog2(NUM_REQ)  index of the current or last granted producer; registered.
- `busy`  out  1  high while state is GRANT or STALL.
- `ovf_err`  out  1  sticky; set when `fifo_overflow` is sampled high; cleared only by reset.

## Operation

- Internal state: `state` (IDLE, GRANT, STALL), `grant_id`, `last_grant`, and `beat_cnt` (4 bits).
- Reset values:
  - `state` = IDLE.
  - `grant_id` = 0 and `last_grant` = NUM_REQ-1, so producer 0 has first priority.
  - `beat_cnt` = 0.
  - `fifo_w_en` = 0, `fifo_din` = 0, `ovf_err` = 0.
  - Consequently `req_ready` = 0 and `busy` = 0.
- IDLE:
  - If `arb_en` is high and any `req_valid` bit is high, select the first set bit scanning upward from `(last_grant+1) mod NUM_REQ`, with wrap-around.
  - Load that index into `grant_id`, clear `beat_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
  - No beats transfer in IDLE.
- GRANT:
  - `req_ready[grant_id]` = !`fifo_full` (combinational); all other ready bits are 0.
  - A beat transfers when `req_valid[grant_id]` && `req_ready[grant_id]`; `beat_cnt` then increments.
  - If `fifo_full` = 1, go to STALL. `beat_cnt` is held.
  - Else, if a beat transfers and `beat_cnt+1` == BURST_MAX, set `last_grant`=`grant_id` and go to IDLE.
  - Else, if `req_valid[grant_id]` = 0, set `last_grant`=`grant_id` and go to IDLE. This is an early release; a producer that drops valid loses its grant.
- STALL:
  - All `req_ready` bits are 0.
  - Return to GRANT when `fifo_full` = 0.
  - The producer's valid may drop here; GRANT then releases on the next cycle.
- Output stage, every cycle:
  - `fifo_w_en` <= transfer; `fifo_din` <= `req_data[grant_id]` on a transfer, otherwise it holds.
- Overflow tracking: `ovf_err` <= `ovf_err` | `fifo_overflow`.
- `arb_en` only gates the IDLE->GRANT transition.
- Reset mid-burst: outputs return to reset values asynchronously, and a beat in the output register is discarded.

## Timing

- Arbitration: `req_valid` sampled high in IDLE at cycle N gives GRANT and `grant_id` valid at N+1. `req_ready` is high at N+1 if `fifo_full` = 0.
- Transfer latency: a transfer at cycle M gives `fifo_w_en`=1 with its data at M+1.
- Throughput: at most BURST_MAX beats per burst, followed by one IDLE arbitration cycle.
  - Sustained all-valid throughput is BURST_MAX/(BURST_MAX+1) beats per cycle.
- Full flag response:
  - `fifo_full` has a combinational effect on `req_ready` in the same cycle.
  - Combined with the FIFO's early full threshold (62) and its input register, at most 2 beats land after `full` rises. This is within capacity.
- Fairness: any continuously valid producer is granted within NUM_REQ-1 bursts.

## Test plan

- Single producer 0 sends 3 beats A0,A1,A2 with `arb_en`=1 after reset. Required: `grant_id`=0, `req_ready[0]` high 1 cycle after valid, `fifo_w_en` pulses 3 cycles carrying A0..A2 one cycle later, then return to IDLE after valid drops.
- All 4 producers continuously valid, BURST_MAX=4. Required: grant order 0,1,2,3,0; exactly 4 beats per grant; one idle cycle between grants; 16 beats in 20 cycles.
- `fifo_full` asserted mid-burst after beat 2 for 5 cycles. Required: `req_ready` drops in the same cycle, STALL is held, and exactly 2 more beats follow after full clears before rotation.
- `arb_en`=0 with all producers valid. Required: no grant and `busy`=0. Deassert `arb_en` during a burst: the burst completes and no new grant follows.
- Pulse `fifo_overflow` for 1 cycle. Required: `ovf_err`=1 permanently until `rst`.
- Assert `rst` mid-burst. Required: `fifo_w_en`=0, `req_ready`=0, `busy`=0 immediately. After release, the first grant goes to producer 0.
